// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: central hold/flush scheduler for the 5-stage pipeline.
// Merges bus wait, interrupt entry, mret, EX redirect, divider busy and
// load-use hazard into a single prioritised hold_flag plus the PC redirect,
// and sequences interrupt entry (drain the pipe, redirect to the vector, ack).
// Optional build macro PIPE_HOLD_PERF_EN adds perf_stall_cnt/perf_flush_cnt.
module pipe_hold_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter int                HOLD_W       = 3,
  parameter int                FLUSH_CYCLES = 1,
  parameter int                DRAIN_CYCLES = 3,
  parameter logic [ADDR_W-1:0] INT_VECTOR   = 32'h0000_0004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_stall,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              mret_req,
  input  logic              div_busy,
  input  logic              ld_use_hazard,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] id_inst_addr,
  output logic [HOLD_W-1:0] hold_flag,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              int_ack,
`ifdef PIPE_HOLD_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic [ADDR_W-1:0] int_epc
);

  // Hold encodings, ordered by how much of the pipe they freeze.
  localparam logic [HOLD_W-1:0] HOLD_NONE = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_PC   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_IF   = HOLD_W'(2);
  localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);
  localparam logic [HOLD_W-1:0] HOLD_PPL  = HOLD_W'(4);

  // Counters are loaded with N-1 because the loading cycle itself is
  // already a held cycle.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENTER = 2'd2
  } int_state_t;

  int_state_t state;
  logic [2:0] flush_cnt;
  logic [2:0] drain_cnt;

  // Prioritised hold/redirect decode from inputs and registered state.
  always_comb begin
    hold_flag = HOLD_NONE;
    jump_flag = 1'b0;
    jump_addr = '0;
    int_ack   = 1'b0;
    if (rst) begin
      hold_flag = HOLD_PPL;
    end else if (bus_stall) begin
      hold_flag = HOLD_PPL;
    end else if (state == ST_ENTER) begin
      hold_flag = HOLD_ID;
      jump_flag = 1'b1;
      jump_addr = INT_VECTOR;
      int_ack   = 1'b1;
    end else if (state == ST_DRAIN) begin
      hold_flag = HOLD_ID;
    end else if (ex_jump_req) begin
      hold_flag = HOLD_ID;
      jump_flag = 1'b1;
      jump_addr = ex_jump_addr;
    end else if (mret_req) begin
      hold_flag = HOLD_ID;
      jump_flag = 1'b1;
      jump_addr = int_epc;
    end else if (flush_cnt != 3'd0) begin
      hold_flag = HOLD_ID;
    end else if (div_busy) begin
      hold_flag = HOLD_IF;
    end else if (ld_use_hazard) begin
      hold_flag = HOLD_PC;
    end
  end

  // Interrupt sequencer and flush/drain counters; all frozen while the bus stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= 3'd0;
      drain_cnt <= 3'd0;
      int_epc   <= '0;
    end else if (!bus_stall) begin
      case (state)
        ST_IDLE: begin
          if (ex_jump_req || mret_req) begin
            flush_cnt <= FLUSH_LOAD;
          end else if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
          end
          // A redirect in the same cycle defers the interrupt; the source holds its level.
          if (int_req && !ex_jump_req && !mret_req) begin
            state     <= ST_DRAIN;
            int_epc   <= id_inst_addr;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
          end
          // A branch resolving mid-drain becomes the return point and restarts the drain.
          if (ex_jump_req) begin
            int_epc   <= ex_jump_addr;
            drain_cnt <= DRAIN_LOAD;
          end else if (drain_cnt == 3'd0) begin
            state <= ST_ENTER;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        ST_ENTER: begin
          flush_cnt <= FLUSH_LOAD;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PIPE_HOLD_PERF_EN
  // Performance counters: held cycles and redirect cycles, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (hold_flag != HOLD_NONE) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (jump_flag) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
